// File: rtl/vc_allocate_if.sv
// vc_allocate_if: request/grant bundle around the VC allocator.
//   req_valid/req_egress/req_vc/req_tail : one routed flit per ingress port
//   req_ready                            : same-cycle grant back to ingress
//   credit_ret                           : per-(egress,VC) downstream slot-freed pulses
//   sa_valid/sa_ingress/sa_vc            : registered grants toward switch traversal
//   stall_count                          : per-egress stall counters (VC_ALLOC_STATS_EN only)
interface vc_allocate_if #(
   parameter int NUM_INPORTS  = 4,
   parameter int NUM_OUTPORTS = 4,
   parameter int NUM_VCS      = 2
);
   localparam int EW = $clog2(NUM_OUTPORTS) + int'(NUM_OUTPORTS == 1);
   localparam int IW = $clog2(NUM_INPORTS) + int'(NUM_INPORTS == 1);
   localparam int VW = $clog2(NUM_VCS) + int'(NUM_VCS == 1);
   logic [NUM_INPORTS-1:0]               req_valid;
   logic [NUM_INPORTS-1:0][EW-1:0]       req_egress;
   logic [NUM_INPORTS-1:0][VW-1:0]       req_vc;
   logic [NUM_INPORTS-1:0]               req_tail;
   logic [NUM_INPORTS-1:0]               req_ready;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] credit_ret;
   logic [NUM_OUTPORTS-1:0]              sa_valid;
   logic [NUM_OUTPORTS-1:0][IW-1:0]      sa_ingress;
   logic [NUM_OUTPORTS-1:0][VW-1:0]      sa_vc;
`ifdef VC_ALLOC_STATS_EN
   logic [NUM_OUTPORTS-1:0][15:0]        stall_count;
   modport master (output req_valid, req_egress, req_vc, req_tail, credit_ret,
                   input req_ready, sa_valid, sa_ingress, sa_vc, stall_count);
   modport slave (input req_valid, req_egress, req_vc, req_tail, credit_ret,
                  output req_ready, sa_valid, sa_ingress, sa_vc, stall_count);
`else
   modport master (output req_valid, req_egress, req_vc, req_tail, credit_ret,
                   input req_ready, sa_valid, sa_ingress, sa_vc);
   modport slave (input req_valid, req_egress, req_vc, req_tail, credit_ret,
                  output req_ready, sa_valid, sa_ingress, sa_vc);
`endif
endinterface

// File: rtl/vc_allocate.sv
// vc_allocate: per-egress round-robin VC allocation with credit tracking and packet locking.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vc_allocate_if.slave (requests in, same-cycle req_ready, credit returns in,
//              registered sa_* grants out)
//   Optional: define VC_ALLOC_STATS_EN to add saturating per-egress stall counters.
module vc_allocate #(
   parameter int NUM_INPORTS  = 4,
   parameter int NUM_OUTPORTS = 4,
   parameter int NUM_VCS      = 2,
   parameter int BUFFER_DEPTH = 8
) (
   input logic          clk,
   input logic          rst,
   vc_allocate_if.slave bus
);
   localparam int NI = NUM_INPORTS;
   localparam int NO = NUM_OUTPORTS;
   localparam int NV = NUM_VCS;
   localparam int EW = $clog2(NO) + int'(NO == 1);
   localparam int IW = $clog2(NI) + int'(NI == 1);
   localparam int VW = $clog2(NV) + int'(NV == 1);
   localparam int CW = $clog2(BUFFER_DEPTH + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                        st_q [NO];
   state_t                        st_d [NO];
   logic [NO-1:0][IW-1:0]         owner_q, owner_d, ptr_q, ptr_d, win, sa_ingress_q, sa_ingress_d;
   logic [NO-1:0][VW-1:0]         owner_vc_q, owner_vc_d, sa_vc_q, sa_vc_d;
   logic [NO-1:0][NV-1:0][CW-1:0] credit_q, credit_d;
   logic [NO-1:0]                 sa_valid_q, sa_valid_d, found;
   logic [NO-1:0][NI-1:0]         elig;
   logic [NO-1:0][NV-1:0]         dec;
   logic [NI-1:0]                 won;
   int                            idx;

   // a locked egress only accepts further flits from its owner on the owner's VC
   always_comb begin
      for (int o = 0; o < NO; o++)
         for (int i = 0; i < NI; i++)
            elig[o][i] = bus.req_valid[i] && bus.req_egress[i] == EW'(o) &&
                         credit_q[o][bus.req_vc[i]] != '0 &&
                         (st_q[o] == IDLE || (owner_q[o] == IW'(i) && owner_vc_q[o] == bus.req_vc[i]));
   end

   // round-robin search starting at ptr_q[o]; first eligible ingress wins
   always_comb begin
      idx = 0;
      found = '0;
      win = '0;
      for (int o = 0; o < NO; o++)
         for (int k = 0; k < NI; k++) begin
            idx = (int'(ptr_q[o]) + k) % NI;
            if (!found[o] && elig[o][idx]) begin
               found[o] = 1'b1;
               win[o] = IW'(idx);
            end
         end
   end

   always_comb begin
      won = '0;
      dec = '0;
      for (int o = 0; o < NO; o++) begin
         for (int i = 0; i < NI; i++)
            if (found[o] && win[o] == IW'(i)) won[i] = 1'b1;
         for (int v = 0; v < NV; v++)
            dec[o][v] = found[o] && bus.req_vc[win[o]] == VW'(v);
      end
   end

   assign bus.req_ready  = rst ? '0 : won;
   assign bus.sa_valid   = sa_valid_q;
   assign bus.sa_ingress = sa_ingress_q;
   assign bus.sa_vc      = sa_vc_q;

   always_comb begin
      owner_d = owner_q;
      owner_vc_d = owner_vc_q;
      ptr_d = ptr_q;
      sa_valid_d = found;
      sa_ingress_d = sa_ingress_q;
      sa_vc_d = sa_vc_q;
      credit_d = credit_q;
      for (int o = 0; o < NO; o++) begin
         st_d[o] = st_q[o];
         sa_ingress_d[o] = found[o] ? win[o] : sa_ingress_q[o];
         sa_vc_d[o] = found[o] ? bus.req_vc[win[o]] : sa_vc_q[o];
         // pointer only advances on packet heads; it stays frozen for the locked packet
         if (found[o] && st_q[o] == IDLE) begin
            ptr_d[o] = (int'(win[o]) == NI - 1) ? '0 : win[o] + 1'b1;
            if (!bus.req_tail[win[o]]) begin
               st_d[o] = LOCKED;
               owner_d[o] = win[o];
               owner_vc_d[o] = bus.req_vc[win[o]];
            end
         end else if (found[o] && bus.req_tail[win[o]]) begin
            st_d[o] = IDLE;
         end
         // grant and return in the same cycle cancel; returns at full depth are dropped
         for (int v = 0; v < NV; v++)
            credit_d[o][v] = (dec[o][v] && !bus.credit_ret[o][v]) ? credit_q[o][v] - 1'b1 :
                             (bus.credit_ret[o][v] && !dec[o][v] && credit_q[o][v] != CW'(BUFFER_DEPTH)) ?
                             credit_q[o][v] + 1'b1 : credit_q[o][v];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < NO; o++) st_q[o] <= IDLE;
         owner_q <= '0;
         owner_vc_q <= '0;
         ptr_q <= '0;
         sa_valid_q <= '0;
         sa_ingress_q <= '0;
         sa_vc_q <= '0;
         credit_q <= {NO*NV{CW'(BUFFER_DEPTH)}};
      end else begin
         for (int o = 0; o < NO; o++) st_q[o] <= st_d[o];
         owner_q <= owner_d;
         owner_vc_q <= owner_vc_d;
         ptr_q <= ptr_d;
         sa_valid_q <= sa_valid_d;
         sa_ingress_q <= sa_ingress_d;
         sa_vc_q <= sa_vc_d;
         credit_q <= credit_d;
      end
   end

`ifdef VC_ALLOC_STATS_EN
   logic [NO-1:0][15:0] stall_q, stall_d;
   logic [NO-1:0]       busy;

   // a stall cycle is one where egress o is requested but nobody wins it
   always_comb begin
      busy = '0;
      stall_d = stall_q;
      for (int o = 0; o < NO; o++) begin
         for (int i = 0; i < NI; i++)
            if (bus.req_valid[i] && bus.req_egress[i] == EW'(o)) busy[o] = 1'b1;
         stall_d[o] = (busy[o] && !found[o] && stall_q[o] != 16'hFFFF) ? stall_q[o] + 16'd1 : stall_q[o];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else stall_q <= stall_d;
   end

   assign bus.stall_count = stall_q;
`endif

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++)
            assert (!bus.req_valid[i] || int'(bus.req_egress[i]) < NO);
         for (int o = 0; o < NO; o++)
            for (int v = 0; v < NV; v++)
               assert (!(bus.credit_ret[o][v] && !dec[o][v] && credit_q[o][v] == CW'(BUFFER_DEPTH)));
      end
   end
endmodule

// File: tb/tb_vc_allocate.sv
// tb_vc_allocate: directed vector table plus hand sequences for credit, lock and reset corners.
module tb_vc_allocate;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vc_allocate_if #(.NUM_INPORTS(4), .NUM_OUTPORTS(4), .NUM_VCS(2)) bus ();

   vc_allocate #(.NUM_INPORTS(4), .NUM_OUTPORTS(4), .NUM_VCS(2), .BUFFER_DEPTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [3:0] v;
      logic [7:0] e;
      logic [3:0] vc;
      logic [3:0] t;
      logic [3:0] rdy;
      logic [3:0] sav;
      logic [7:0] sai;
      logic [3:0] savc;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] v, input logic [7:0] e, input logic [3:0] vc,
                      input logic [3:0] t, input logic [7:0] cr, output logic [3:0] r);
      bus.req_valid = v;
      bus.req_egress = e;
      bus.req_vc = vc;
      bus.req_tail = t;
      bus.credit_ret = cr;
      #1 r = bus.req_ready;
      @(posedge clk);
      #1;
      bus.credit_ret = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.credit_ret = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] r;
      vecs[0] = '{4'b0001, 8'b00_00_00_10, 4'b0001, 4'b1111, 4'b0001, 4'b0100, 8'b00_00_00_00, 4'b0100};
      vecs[1] = '{4'b1011, 8'b01_01_01_01, 4'b0000, 4'b1111, 4'b0001, 4'b0010, 8'b00_00_00_00, 4'b0100};
      vecs[2] = '{4'b1010, 8'b01_01_01_01, 4'b0000, 4'b1111, 4'b0010, 4'b0010, 8'b00_00_01_00, 4'b0100};
      vecs[3] = '{4'b1000, 8'b01_01_01_01, 4'b0000, 4'b1111, 4'b1000, 4'b0010, 8'b00_00_11_00, 4'b0100};
      vecs[4] = '{4'b0000, 8'b01_01_01_01, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'b00_00_11_00, 4'b0100};
      vecs[5] = '{4'b1111, 8'b10_00_11_00, 4'b0110, 4'b1111, 4'b1011, 4'b1101, 8'b01_11_11_00, 4'b1000};
      vecs[6] = '{4'b0101, 8'b00_00_00_00, 4'b0100, 4'b1111, 4'b0100, 4'b0001, 8'b01_11_11_10, 4'b1001};
      vecs[7] = '{4'b0001, 8'b00_00_00_00, 4'b0000, 4'b1111, 4'b0001, 4'b0001, 8'b01_11_11_00, 4'b1000};
      bus.req_valid = '0;
      bus.req_egress = '0;
      bus.req_vc = '0;
      bus.req_tail = '0;
      bus.credit_ret = '0;
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = 4'b1111;
      #1;
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_sa_valid", 32'(bus.sa_valid), 0);
      check("rst_sa_ingress", 32'(bus.sa_ingress), 0);
      check("rst_sa_vc", 32'(bus.sa_vc), 0);
`ifdef VC_ALLOC_STATS_EN
      check("rst_stall_count", 32'(bus.stall_count), 0);
`endif
      bus.req_valid = '0;
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         cyc(vecs[n].v, vecs[n].e, vecs[n].vc, vecs[n].t, 8'h00, r);
         check($sformatf("vec%0d_ready", n), 32'(r), 32'(vecs[n].rdy));
         check($sformatf("vec%0d_sa_valid", n), 32'(bus.sa_valid), 32'(vecs[n].sav));
         check($sformatf("vec%0d_sa_ingress", n), 32'(bus.sa_ingress), 32'(vecs[n].sai));
         check($sformatf("vec%0d_sa_vc", n), 32'(bus.sa_vc), 32'(vecs[n].savc));
      end

      do_reset();
      for (int n = 0; n < 8; n++) begin
         cyc(4'b0001, 8'h00, 4'b0000, 4'b1111, 8'h00, r);
         check($sformatf("exh_grant%0d", n), 32'(r), 32'b0001);
      end
      check("exh_sa_valid_last", 32'(bus.sa_valid), 32'b0001);
      for (int n = 0; n < 3; n++) begin
         cyc(4'b0001, 8'h00, 4'b0000, 4'b1111, 8'h00, r);
         check($sformatf("exh_stall%0d", n), 32'(r), 0);
      end
      check("exh_sa_valid_stall", 32'(bus.sa_valid), 0);
      cyc(4'b0001, 8'h00, 4'b0000, 4'b1111, 8'h01, r);
      check("exh_ret_cycle", 32'(r), 0);
      cyc(4'b0001, 8'h00, 4'b0000, 4'b1111, 8'h00, r);
      check("exh_after_ret", 32'(r), 32'b0001);
`ifdef VC_ALLOC_STATS_EN
      check("exh_stall_count", 32'(bus.stall_count[0]), 4);
`endif
      cyc(4'b0011, 8'h00, 4'b0010, 4'b1111, 8'h00, r);
      check("exh_other_vc", 32'(r), 32'b0010);
      check("exh_other_vc_ingress", 32'(bus.sa_ingress[0]), 1);
      check("exh_other_vc_vc", 32'(bus.sa_vc[0]), 1);
`ifdef VC_ALLOC_STATS_EN
      check("exh_stall_count_hold", 32'(bus.stall_count[0]), 4);
`endif

      do_reset();
      cyc(4'b0100, 8'hFF, 4'b0000, 4'b0000, 8'h00, r);
      check("lock_head", 32'(r), 32'b0100);
      cyc(4'b0101, 8'hFF, 4'b0001, 4'b0001, 8'b0100_0000, r);
      check("lock_body", 32'(r), 32'b0100);
      cyc(4'b0101, 8'hFF, 4'b0001, 4'b0101, 8'h00, r);
      check("lock_tail", 32'(r), 32'b0100);
      check("lock_tail_ingress", 32'(bus.sa_ingress[3]), 2);
      cyc(4'b0001, 8'hFF, 4'b0001, 4'b0001, 8'h00, r);
      check("lock_release", 32'(r), 32'b0001);
      check("lock_release_ingress", 32'(bus.sa_ingress[3]), 0);
      check("lock_release_vc", 32'(bus.sa_vc[3]), 1);
      for (int n = 0; n < 7; n++) begin
         cyc(4'b0100, 8'hFF, 4'b0000, 4'b1111, 8'h00, r);
         check($sformatf("lock_credit%0d", n), 32'(r), (n < 6) ? 32'b0100 : 32'b0000);
      end

      do_reset();
      cyc(4'b0100, 8'hFF, 4'b0000, 4'b0000, 8'h00, r);
      check("mid_head", 32'(r), 32'b0100);
      bus.req_valid = 4'b0101;
      bus.req_tail = 4'b0001;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(bus.req_ready), 0);
      check("mid_rst_sa_valid", 32'(bus.sa_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(4'b0101, 8'hFF, 4'b0000, 4'b0001, 8'h00, r);
      check("mid_release_winner", 32'(r), 32'b0001);
      check("mid_release_ingress", 32'(bus.sa_ingress[3]), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
